// File: rtl/best_nofm_busy.sv
// best_nofm_busy: captures one set of key pattern words and extracts up to NBEST
// best keys in rank order, one pairwise-tree pass per cycle, blanking winners' neighbours.
`default_nettype none

module best_nofm_busy #(
  parameter int MXKEY  = 32,
  parameter int MXKEYB = $clog2(MXKEY),
  parameter int MXPATB = 7,
  parameter int MXPATC = 3,
  parameter int NBEST  = 2,
  parameter int NFB    = $clog2(NBEST + 1),
  parameter int BLANK  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [MXKEY*MXPATB-1:0]   pat_in,
  input  logic [MXKEY*MXPATC-1:0]   carry_in,
  input  logic [MXKEY-1:0]          bsy_in,
  input  logic [MXPATB-2:0]         thresh,
  output logic                      busy,
  output logic                      start_lost,
  output logic                      best_vld,
  output logic [MXPATB-1:0]         best_pat,
  output logic [MXKEYB-1:0]         best_key,
  output logic [MXPATC-1:0]         best_carry,
  output logic [((NBEST > 1) ? $clog2(NBEST) : 1)-1:0] best_rank,
  output logic                      done,
  output logic [NFB-1:0]            nfound
);

  localparam int RKB  = (NBEST > 1) ? $clog2(NBEST) : 1;
  localparam int MXQB = MXPATB - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic [MXKEY*MXPATB-1:0] r_pat;
  logic [MXKEY*MXPATC-1:0] r_carry;
  logic [MXQB-1:0]         r_thresh;
  logic [MXKEY-1:0]        r_mask;
  logic [NFB-1:0]          r_cnt;

  // Heap-ordered tree: node n has children 2n (lower keys) and 2n+1; leaves at MXKEY+k.
  logic                    w_nv [2*MXKEY-1:1];
  logic [MXQB-1:0]         w_nq [2*MXKEY-1:2];
  logic [MXKEYB-1:0]       w_nk [2*MXKEY-1:1];

  genvar gk, gn;
  generate
    for (gk = 0; gk < MXKEY; gk++) begin : g_leaf
      logic [MXQB-1:0] w_q;
      assign w_q               = r_pat[gk*MXPATB+1 +: MXQB];
      assign w_nv[MXKEY+gk]    = !r_mask[gk] && (w_q >= r_thresh) && (w_q != '0);
      assign w_nq[MXKEY+gk]    = w_q;
      assign w_nk[MXKEY+gk]    = MXKEYB'(gk);
    end
    for (gn = 1; gn < MXKEY; gn++) begin : g_node
      logic w_left;
      // Ties favour the left child, so equal quality resolves to the lower key.
      assign w_left  = w_nv[2*gn] && (!w_nv[2*gn+1] || (w_nq[2*gn] >= w_nq[2*gn+1]));
      assign w_nv[gn] = w_nv[2*gn] || w_nv[2*gn+1];
      assign w_nk[gn] = w_left ? w_nk[2*gn] : w_nk[2*gn+1];
      if (gn > 1) begin : g_q
        assign w_nq[gn] = w_left ? w_nq[2*gn] : w_nq[2*gn+1];
      end
    end
  endgenerate

  logic                w_win_vld;
  logic [MXKEYB-1:0]   w_win_key;
  logic [MXPATB-1:0]   w_win_pat;
  logic [MXPATC-1:0]   w_win_carry;
  logic [MXKEY-1:0]    w_blank;
  logic                w_take;
  logic                w_finish;

  assign w_win_vld   = w_nv[1];
  assign w_win_key   = w_nk[1];
  assign w_win_pat   = r_pat[w_win_key*MXPATB +: MXPATB];
  assign w_win_carry = r_carry[w_win_key*MXPATC +: MXPATC];

  always_comb begin
    w_blank = '0;
    for (int k = 0; k < MXKEY; k++) begin
      if ((k + BLANK >= int'(w_win_key)) && (k <= int'(w_win_key) + BLANK))
        w_blank[k] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (w_finish) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    w_take   = (r_state == S_SCAN) && w_win_vld;
    w_finish = (r_state == S_SCAN) && (!w_win_vld || (r_cnt == NFB'(NBEST - 1)));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pat      <= '0;
      r_carry    <= '0;
      r_thresh   <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
      start_lost <= 1'b0;
      best_vld   <= 1'b0;
      best_pat   <= '0;
      best_key   <= '0;
      best_carry <= '0;
      best_rank  <= '0;
      done       <= 1'b0;
      nfound     <= '0;
    end else begin
      start_lost <= start && (r_state != S_IDLE);
      best_vld   <= w_take;
      done       <= w_finish;
      if ((r_state == S_IDLE) && start) begin
        r_pat    <= pat_in;
        r_carry  <= carry_in;
        r_thresh <= thresh;
        r_mask   <= bsy_in;
        r_cnt    <= '0;
      end
      if (w_take) begin
        best_pat   <= w_win_pat;
        best_key   <= w_win_key;
        best_carry <= w_win_carry;
        best_rank  <= RKB'(r_cnt);
        r_mask     <= r_mask | w_blank;
        r_cnt      <= r_cnt + NFB'(1);
      end
      if (w_finish)
        nfound <= w_take ? (r_cnt + NFB'(1)) : r_cnt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_best_nofm_busy.sv
// Scoreboard bench for best_nofm_busy: a linear-scan reference model queues expected
// winner/done events with their cycles; a negedge monitor pops and compares them.
`default_nettype none

module tb_best_nofm_busy;

  localparam int MXKEY  = 32;
  localparam int MXKEYB = 5;
  localparam int MXPATB = 7;
  localparam int MXPATC = 3;
  localparam int NBEST  = 2;
  localparam int NFB    = 2;
  localparam int BLANK  = 1;

  logic                    clock;
  logic                    reset_n;
  logic                    start;
  logic [MXKEY*MXPATB-1:0] pat_in;
  logic [MXKEY*MXPATC-1:0] carry_in;
  logic [MXKEY-1:0]        bsy_in;
  logic [MXPATB-2:0]       thresh;
  logic                    busy;
  logic                    start_lost;
  logic                    best_vld;
  logic [MXPATB-1:0]       best_pat;
  logic [MXKEYB-1:0]       best_key;
  logic [MXPATC-1:0]       best_carry;
  logic [0:0]              best_rank;
  logic                    done;
  logic [NFB-1:0]          nfound;

  best_nofm_busy #(
    .MXKEY(MXKEY), .MXKEYB(MXKEYB), .MXPATB(MXPATB), .MXPATC(MXPATC),
    .NBEST(NBEST), .NFB(NFB), .BLANK(BLANK)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pat_in(pat_in),
    .carry_in(carry_in), .bsy_in(bsy_in), .thresh(thresh), .busy(busy),
    .start_lost(start_lost), .best_vld(best_vld), .best_pat(best_pat),
    .best_key(best_key), .best_carry(best_carry), .best_rank(best_rank),
    .done(done), .nfound(nfound)
  );

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [6:0] pat;
    logic [4:0] key;
    logic [2:0] carry;
    int         rank;
    int         nf;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_ev;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [6:0] tp [MXKEY];
  logic [2:0] tc [MXKEY];
  logic [31:0] tbsy;
  logic [6:0] last_pat;
  logic [4:0] last_key;
  logic [2:0] last_carry;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk(sb[0].is_done ? "done_missing" : "vld_missing", 32'(sb[0].cyc), 32'(cyc));
      void'(sb.pop_front());
    end
    if (best_vld === 1'b1) begin
      if (sb.size() > 0 && !sb[0].is_done) begin
        mon_ev = sb.pop_front();
        chk("vld_cyc", 32'(cyc), 32'(mon_ev.cyc));
        chk("best_key", 32'(best_key), 32'(mon_ev.key));
        chk("best_pat", 32'(best_pat), 32'(mon_ev.pat));
        chk("best_carry", 32'(best_carry), 32'(mon_ev.carry));
        chk("best_rank", 32'(best_rank), 32'(mon_ev.rank));
      end else chk("vld_unexpected", 32'd1, 32'd0);
    end
    if (done === 1'b1) begin
      if (sb.size() > 0 && sb[0].is_done) begin
        mon_ev = sb.pop_front();
        chk("done_cyc", 32'(cyc), 32'(mon_ev.cyc));
        chk("nfound", 32'(nfound), 32'(mon_ev.nf));
        chk("done_busy", 32'(busy), 32'd1);
      end else chk("done_unexpected", 32'd1, 32'd0);
    end
  end

  // Reference: linear scan, strictly-greater update keeps the lowest key on ties.
  task automatic model(input int c, input logic [5:0] th);
    logic [31:0] m;
    int nf;
    int passes;
    ev_t e;
    m  = tbsy;
    nf = 0;
    for (int r = 0; r < NBEST; r++) begin
      int b;
      b = -1;
      for (int k = 0; k < MXKEY; k++)
        if (!m[k] && tp[k][6:1] >= th && tp[k][6:1] != 0 && (b < 0 || tp[k][6:1] > tp[b][6:1]))
          b = k;
      if (b < 0) break;
      e = '{cyc: c + 2 + r, is_done: 1'b0, pat: tp[b], key: 5'(b), carry: tc[b], rank: r, nf: 0};
      sb.push_back(e);
      last_pat = tp[b]; last_key = 5'(b); last_carry = tc[b];
      for (int j = b - BLANK; j <= b + BLANK; j++)
        if (j >= 0 && j < MXKEY) m[j] = 1'b1;
      nf++;
    end
    passes = (nf == NBEST) ? NBEST : nf + 1;
    e = '{cyc: c + 1 + passes, is_done: 1'b1, pat: 7'd0, key: 5'd0, carry: 3'd0, rank: 0, nf: nf};
    sb.push_back(e);
  endtask

  task automatic scramble();
    pat_in   = {7{$urandom()}};
    carry_in = {3{$urandom()}};
    bsy_in   = $urandom();
    thresh   = 6'($urandom());
  endtask

  task automatic clear_pats();
    for (int k = 0; k < MXKEY; k++) begin
      tp[k] = 7'd0;
      tc[k] = 3'($urandom_range(0, 7));
    end
    tbsy = 32'd0;
  endtask

  task automatic run_scan(input logic [5:0] th, input int lost_at, input int rst_at);
    int c;
    @(negedge clock);
    for (int k = 0; k < MXKEY; k++) begin
      pat_in[k*MXPATB +: MXPATB]   = tp[k];
      carry_in[k*MXPATC +: MXPATC] = tc[k];
    end
    bsy_in = tbsy;
    thresh = th;
    start  = 1'b1;
    c = cyc;
    model(c, th);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      scramble();
      start = (k == lost_at);
      if (lost_at >= 0 && k == lost_at + 1) chk("start_lost_hi", 32'(start_lost), 32'd1);
      if (lost_at >= 0 && k == lost_at + 2) chk("start_lost_lo", 32'(start_lost), 32'd0);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(best_vld), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_best", {best_pat, best_key, best_carry, best_rank}, 32'd0);
        chk("rst_nfound", 32'(nfound), 32'd0);
        reset_n = 1'b1;
      end
      if (k == rst_at) begin
        reset_n = 1'b0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      end
    end
    start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clock);
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0;
    pat_in = '0; carry_in = '0; bsy_in = '0; thresh = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", {best_vld, done, start_lost, nfound, best_key, best_pat}, 32'd0);
    reset_n = 1'b1;

    clear_pats(); tp[5] = 7'h2C; tp[20] = 7'h30;
    run_scan(6'd1, -1, -1);

    clear_pats(); tp[10] = 7'h2A; tp[11] = 7'h2A; tp[30] = 7'h20;
    run_scan(6'd1, -1, -1);

    clear_pats(); tbsy[0] = 1'b1; tp[0] = 7'h3E; tp[31] = 7'h10;
    run_scan(6'd1, -1, -1);

    clear_pats();
    for (int k = 0; k < MXKEY; k++) tp[k] = 7'($urandom_range(0, 7'h2F));
    run_scan(6'h18, -1, -1);
    chk("hold_key", 32'(best_key), 32'(last_key));
    chk("hold_pat", 32'(best_pat), 32'(last_pat));
    chk("hold_carry", 32'(best_carry), 32'(last_carry));

    clear_pats(); tp[5] = 7'h2C; tp[20] = 7'h30;
    run_scan(6'd1, 1, -1);

    clear_pats(); tp[5] = 7'h2C; tp[20] = 7'h30;
    run_scan(6'd1, -1, 1);

    for (int t = 0; t < 12; t++) begin
      clear_pats();
      for (int k = 0; k < MXKEY; k++)
        tp[k] = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom());
      tbsy = $urandom() & $urandom();
      run_scan(6'($urandom_range(0, 40)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
